// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared definitions for the 7-segment scan decoder: the 16
//               active-low segment patterns (DP bit set, i.e. unlit), the
//               decimal-point bit position and the scan state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // Active-low patterns, bit 0 = segment a, bit 7 = DP (unlit here).
    localparam logic [7:0] C_PAT_0 = 8'hC0;
    localparam logic [7:0] C_PAT_1 = 8'hF9;
    localparam logic [7:0] C_PAT_2 = 8'hA4;
    localparam logic [7:0] C_PAT_3 = 8'hB0;
    localparam logic [7:0] C_PAT_4 = 8'h99;
    localparam logic [7:0] C_PAT_5 = 8'h92;
    localparam logic [7:0] C_PAT_6 = 8'h82;
    localparam logic [7:0] C_PAT_7 = 8'hF8;
    localparam logic [7:0] C_PAT_8 = 8'h80;
    localparam logic [7:0] C_PAT_9 = 8'h90;
    localparam logic [7:0] C_PAT_A = 8'h88;
    localparam logic [7:0] C_PAT_B = 8'h83;
    localparam logic [7:0] C_PAT_C = 8'hC6;
    localparam logic [7:0] C_PAT_D = 8'hA1;
    localparam logic [7:0] C_PAT_E = 8'h86;
    localparam logic [7:0] C_PAT_F = 8'h8E;

    // Bit position of the decimal point within each 8-bit digit pattern.
    localparam int C_DP_BIT = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : seg7_pkg

`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_decode
// Description : Combinational 7-segment pattern to hex nibble decoder. Only
//               segments a..g are compared; the decimal point is ignored.
//               Unknown patterns give nibble 0 with err set.
// Ports       : pattern [7:0] - active-low segment pattern (bit 7 = DP)
//               nibble  [3:0] - decoded hex value
//               err           - pattern not in the table
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [7:0] pattern,
    output logic [3:0] nibble,
    output logic       err
);

    // The DP bit is deliberately not part of the match.
    logic unused_dp;
    assign unused_dp = pattern[C_DP_BIT];

    always_comb begin
        nibble = 4'h0;
        err    = 1'b0;
        case (pattern[6:0])
            C_PAT_0[6:0]: nibble = 4'h0;
            C_PAT_1[6:0]: nibble = 4'h1;
            C_PAT_2[6:0]: nibble = 4'h2;
            C_PAT_3[6:0]: nibble = 4'h3;
            C_PAT_4[6:0]: nibble = 4'h4;
            C_PAT_5[6:0]: nibble = 4'h5;
            C_PAT_6[6:0]: nibble = 4'h6;
            C_PAT_7[6:0]: nibble = 4'h7;
            C_PAT_8[6:0]: nibble = 4'h8;
            C_PAT_9[6:0]: nibble = 4'h9;
            C_PAT_A[6:0]: nibble = 4'hA;
            C_PAT_B[6:0]: nibble = 4'hB;
            C_PAT_C[6:0]: nibble = 4'hC;
            C_PAT_D[6:0]: nibble = 4'hD;
            C_PAT_E[6:0]: nibble = 4'hE;
            C_PAT_F[6:0]: nibble = 4'hF;
            default: begin
                nibble = 4'h0;
                err    = 1'b1;
            end
        endcase
    end

endmodule : seg7_decode

`default_nettype wire

// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_decoder
// Description : On a START pulse, snapshots NUM_DIGITS 7-segment patterns and
//               decodes them one digit per cycle through a single shared
//               seg7_decode instance, then publishes VALUE/ERR with a
//               one-cycle VALID pulse. Latency is NUM_DIGITS+1 edges.
// Parameters  : NUM_DIGITS (1..8, default 6)
// Macro       : SEG7_DP_CAPTURE_EN - when defined, adds the DP output holding
//               the captured (active-high) decimal points.
// Ports       : CLOCK_50 - clock, rising edge
//               RESET    - synchronous active-high reset
//               START    - single-cycle scan request (ignored while busy)
//               HEX_IN   - active-low patterns, digit k at [8k+7:8k]
//               BUSY     - scan in progress
//               VALID    - one-cycle result strobe
//               VALUE    - decoded nibbles, digit k at [4k+3:4k]
//               ERR      - per-digit unrecognised-pattern flag
//               DP       - per-digit decimal point (macro only)
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 6
)
(
    input  logic                    CLOCK_50,
    input  logic                    RESET,
    input  logic                    START,
    input  logic [8*NUM_DIGITS-1:0] HEX_IN,
    output logic                    BUSY,
    output logic                    VALID,
    output logic [4*NUM_DIGITS-1:0] VALUE,
    output logic [NUM_DIGITS-1:0]   ERR
`ifdef SEG7_DP_CAPTURE_EN
    ,
    output logic [NUM_DIGITS-1:0]   DP
`endif
);

    localparam int              IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    state_t                  r_state;
    state_t                  w_next_state;
    logic [8*NUM_DIGITS-1:0] r_snap;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_work_value;
    logic [NUM_DIGITS-1:0]   r_work_err;
    logic                    r_valid;
    logic                    w_start_ok;
    logic [7:0]              w_pattern;
    logic [3:0]              w_nibble;
    logic                    w_err;

    // VALID is high in the first IDLE cycle after DONE; a START seen in that
    // cycle is the back-to-back case and must not launch a new scan.
    assign w_start_ok = (r_state == ST_IDLE) && START && !r_valid;

    assign BUSY  = (r_state != ST_IDLE);
    assign VALID = r_valid;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_start_ok)          w_next_state = ST_SCAN;
            ST_SCAN: if (r_idx == C_LAST_IDX) w_next_state = ST_DONE;
            ST_DONE:                          w_next_state = ST_IDLE;
            default:                          w_next_state = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Digit select from the snapshot into the shared decoder
    // ------------------------------------------------------------------
    always_comb begin
        w_pattern = r_snap[7:0];
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_pattern = r_snap[8*k +: 8];
            end
        end
    end

    seg7_decode u_decode (
        .pattern (w_pattern),
        .nibble  (w_nibble),
        .err     (w_err)
    );

    // ------------------------------------------------------------------
    // Datapath: snapshot, per-digit accumulation, result publication
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_snap       <= '0;
            r_idx        <= '0;
            r_work_value <= '0;
            r_work_err   <= '0;
            r_valid      <= 1'b0;
            VALUE        <= '0;
            ERR          <= '0;
`ifdef SEG7_DP_CAPTURE_EN
            DP           <= '0;
`endif
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        r_snap       <= HEX_IN;
                        r_idx        <= '0;
                        r_work_value <= '0;
                        r_work_err   <= '0;
                    end
                end
                ST_SCAN: begin
                    for (int k = 0; k < NUM_DIGITS; k++) begin
                        if (r_idx == IDX_W'(k)) begin
                            r_work_value[4*k +: 4] <= w_nibble;
                            r_work_err[k]          <= w_err;
                        end
                    end
                    r_idx <= r_idx + 1'b1;
                end
                ST_DONE: begin
                    VALUE   <= r_work_value;
                    ERR     <= r_work_err;
                    r_valid <= 1'b1;
`ifdef SEG7_DP_CAPTURE_EN
                    // Snapshot is still intact here; DP is active-low on input.
                    for (int k = 0; k < NUM_DIGITS; k++) begin
                        DP[k] <= ~r_snap[8*k + C_DP_BIT];
                    end
`endif
                end
                default: begin
                end
            endcase
        end
    end

endmodule : seg7_scan_decoder

`default_nettype wire

// File: tb/tb_seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_decoder
// Description : Self-checking bench for seg7_scan_decoder (NUM_DIGITS = 6).
//               Table of directed scans plus hand-written sequences for
//               snapshot isolation, START re-pulsing and mid-scan reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_decoder;

    localparam int NUM_DIGITS = 6;
    localparam int C_LATENCY  = NUM_DIGITS + 1;

    logic        clk;
    logic        rst;
    logic        start;
    logic [47:0] hex_in;
    logic        busy;
    logic        valid;
    logic [23:0] value;
    logic [5:0]  err;
`ifdef SEG7_DP_CAPTURE_EN
    logic [5:0]  dp;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    seg7_scan_decoder #(.NUM_DIGITS(NUM_DIGITS)) dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .START    (start),
        .HEX_IN   (hex_in),
        .BUSY     (busy),
        .VALID    (valid),
        .VALUE    (value),
        .ERR      (err)
`ifdef SEG7_DP_CAPTURE_EN
        ,
        .DP       (dp)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [47:0] hex;
        logic [23:0] exp_value;
        logic [5:0]  exp_err;
    } vec_t;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive a one-cycle START; returns 1ns after the edge that sampled it.
    task automatic pulse_start(input logic [47:0] hex);
        @(posedge clk); #1;
        hex_in = hex;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    // Follows pulse_start: checks latency, BUSY length, result and pulse width.
    task automatic wait_result(input logic [23:0] ev, input logic [5:0] ee);
        int lat;
        int busy_cnt;
        bit got;
        lat = 0; busy_cnt = 0; got = 1'b0;
        for (int i = 1; i <= 20 && !got; i++) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            if (valid) begin
                got = 1'b1;
                lat = i;
            end
        end
        check("valid_seen", 64'(got), 64'd1);
        check("latency", 64'(lat), 64'(C_LATENCY));
        check("busy_cycles", 64'(busy_cnt), 64'(C_LATENCY));
        check("busy_low_at_valid", 64'(busy), 64'd0);
        check("value", 64'(value), 64'(ev));
        check("err", 64'(err), 64'(ee));
        @(posedge clk); #1;
        check("valid_one_cycle", 64'(valid), 64'd0);
    endtask

    vec_t vecs [5];

    initial begin
        int nv;
        int bad;

        vecs[0] = '{48'h80F8829299B0, 24'h876543, 6'b000000};
        vecs[1] = '{48'hC0C0C0FFC0C0, 24'h000000, 6'b000100};
        vecs[2] = '{48'h8E86A1C68388, 24'hFEDCBA, 6'b000000};
        vecs[3] = '{48'h9040F9A455FF, 24'h901200, 6'b000011};
        vecs[4] = '{48'h19F9C0B00E80, 24'h4103F8, 6'b000000};

        rst = 1'b1; start = 1'b0; hex_in = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_valid", 64'(valid), 64'd0);
        check("reset_value", 64'(value), 64'd0);
        check("reset_err", 64'(err), 64'd0);

        for (int v = 0; v < 5; v++) begin
            pulse_start(vecs[v].hex);
            wait_result(vecs[v].exp_value, vecs[v].exp_err);
        end

        // Result holds while inputs change and no scan runs
        hex_in = 48'h0;
        repeat (5) @(posedge clk);
        #1;
        check("hold_value", 64'(value), 64'h4103F8);
        check("hold_valid", 64'(valid), 64'd0);

        // Inputs change right after the snapshot
        pulse_start(48'h80F8829299B0);
        hex_in = 48'h8E8E8E8E8E8E;
        wait_result(24'h876543, 6'b000000);
        pulse_start(48'h8E8E8E8E8E8E);
        wait_result(24'hFFFFFF, 6'b000000);

        // START re-pulsed during SCAN and in the VALID cycle
        pulse_start(48'hC0F9A4B09992);
        nv = 0; bad = 0;
        for (int i = 0; i < 20; i++) begin
            bit sv;
            sv    = valid;
            start = (i == 2) || (i == 4) || valid;
            @(posedge clk); #1;
            start = 1'b0;
            if (valid) nv++;
            if (sv && busy) bad++;
        end
        check("repulse_valid_count", 64'(nv), 64'd1);
        check("repulse_no_restart", 64'(bad), 64'd0);
        check("repulse_value", 64'(value), 64'h012345);
        check("repulse_idle", 64'(busy), 64'd0);

        // Reset in scan cycle 3, coincident with START
        pulse_start(48'h80F8829299B0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_valid", 64'(valid), 64'd0);
        check("abort_value", 64'(value), 64'd0);
        check("abort_err", 64'(err), 64'd0);
        nv = 0; bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (valid) nv++;
            if (busy) bad++;
        end
        check("abort_no_valid", 64'(nv), 64'd0);
        check("abort_stays_idle", 64'(bad), 64'd0);
        pulse_start(48'hC0C0C0C0C0F9);
        wait_result(24'h000001, 6'b000000);

`ifdef SEG7_DP_CAPTURE_EN
        pulse_start(48'hC0C0C0C0C079);
        wait_result(24'h000001, 6'b000000);
        check("dp_capture", 64'(dp), 64'h01);
        pulse_start(48'h40F940C0C0C0);
        wait_result(24'h010000, 6'b000000);
        check("dp_capture2", 64'(dp), 64'h28);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_seg7_scan_decoder

`default_nettype wire
